// File: rtl/sync_fifo_thresh.sv
// rtl/sync_fifo_thresh.sv - single-clock FWFT FIFO, any depth, occupancy count and thresholds
// Optional sticky overflow/underflow flags: define SYNC_FIFO_ERR_FLAGS_EN.
module sync_fifo_thresh #(
    parameter int DEPTH         = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         wr_en_i,
    input  logic [DATA_WIDTH-1:0]        wr_data_i,
    input  logic                         rd_en_i,
    output logic [DATA_WIDTH-1:0]        rd_data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         almost_full_o,
    output logic                         almost_empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         overflow_o,
    output logic                         underflow_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_LAST  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  push_acc;
    logic                  pop_acc;

    // Pointers run 0..DEPTH-1 and wrap explicitly, so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Flags come from the registered count only; requests never reach outputs combinationally.
    assign full_o         = (count_q == COUNT_MAX);
    assign empty_o        = (count_q == '0);
    assign almost_full_o  = (int'(count_q) >= AFULL_THRESH);
    assign almost_empty_o = (int'(count_q) <= AEMPTY_THRESH);
    assign count_o        = count_q;

    // A push to a full FIFO is dropped even if a pop happens in the same cycle.
    assign push_acc = wr_en_i && !full_o  && !flush_i;
    assign pop_acc  = rd_en_i && !empty_o && !flush_i;

    // Head entry falls through; forced to zero so stale storage never leaks out.
    assign rd_data_o = empty_o ? '0 : mem[rd_ptr_q];

    // Storage write; the array itself is never reset.
    always_ff @(posedge clk_i) begin
        if (push_acc) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointer and occupancy state; flush behaves like a synchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_acc) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_acc, pop_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky error flags record any rejected request until reset or flush.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (flush_i) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en_i && full_o) begin
                overflow_q <= 1'b1;
            end
            if (rd_en_i && empty_o) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
`else
    assign overflow_o  = 1'b0;
    assign underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// tb/tb_sync_fifo_thresh.sv - self-checking bench for sync_fifo_thresh
module tb_sync_fifo_thresh;

    localparam int DEPTH = 5;
    localparam int DW    = 8;
    localparam int AF    = 4;
    localparam int AE    = 1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          flush_i;
    logic          wr_en_i;
    logic [DW-1:0] wr_data_i;
    logic          rd_en_i;
    logic [DW-1:0] rd_data_o;
    logic          full_o;
    logic          empty_o;
    logic          almost_full_o;
    logic          almost_empty_o;
    logic [2:0]    count_o;
    logic          overflow_o;
    logic          underflow_o;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mq[$];
    logic          m_ovf;
    logic          m_unf;

    typedef struct packed {
        logic          wr;
        logic          rd;
        logic [DW-1:0] data;
        logic [3:0]    exp_count;
        logic [DW-1:0] exp_rdata;
        logic          exp_full;
        logic          exp_empty;
    } vec_t;

    vec_t vecs[13];

    sync_fifo_thresh #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .wr_en_i(wr_en_i), .wr_data_i(wr_data_i), .rd_en_i(rd_en_i),
        .rd_data_o(rd_data_o), .full_o(full_o), .empty_o(empty_o),
        .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
        .count_o(count_o), .overflow_o(overflow_o), .underflow_o(underflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // Reference: a queue plus sticky bits, applied once per clock edge.
    task automatic model_step(input logic f, input logic w, input logic r, input logic [DW-1:0] d);
        int n;
        n = mq.size();
        if (f) begin
            model_clear();
        end else begin
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            if (w && n == DEPTH) m_ovf = 1'b1;
            if (r && n == 0)     m_unf = 1'b1;
`endif
            if (r && n > 0)     void'(mq.pop_front());
            if (w && n < DEPTH) mq.push_back(d);
        end
    endtask

    task automatic check_model(input string tag);
        int n;
        n = mq.size();
        check({tag, ".count"},  32'(count_o),        32'(n));
        check({tag, ".full"},   32'(full_o),         32'(n == DEPTH));
        check({tag, ".empty"},  32'(empty_o),        32'(n == 0));
        check({tag, ".afull"},  32'(almost_full_o),  32'(n >= AF));
        check({tag, ".aempty"}, 32'(almost_empty_o), 32'(n <= AE));
        check({tag, ".rdata"},  32'(rd_data_o),      (n > 0) ? 32'(mq[0]) : 32'd0);
        check({tag, ".ovf"},    32'(overflow_o),     32'(m_ovf));
        check({tag, ".unf"},    32'(underflow_o),    32'(m_unf));
    endtask

    // Drive one cycle of requests starting just after a rising edge, then check 1 time unit after the next.
    task automatic step(input string tag, input logic f, input logic w, input logic r, input logic [DW-1:0] d);
        flush_i   = f;
        wr_en_i   = w;
        rd_en_i   = r;
        wr_data_i = d;
        @(posedge clk_i);
        model_step(f, w, r, d);
        #1;
        flush_i = 1'b0;
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        check_model(tag);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #3;
        model_clear();
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int ph;
        rst_i     = 1'b1;
        flush_i   = 1'b0;
        wr_en_i   = 1'b0;
        rd_en_i   = 1'b0;
        wr_data_i = '0;
        model_clear();

        vecs[0]  = '{1'b1, 1'b0, 8'h11, 4'd1, 8'h11, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 8'h22, 4'd2, 8'h11, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 8'h33, 4'd3, 8'h11, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 8'h44, 4'd4, 8'h11, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 8'h55, 4'd5, 8'h11, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 8'h66, 4'd5, 8'h11, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 8'h77, 4'd4, 8'h22, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'h00, 4'd3, 8'h33, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 8'h00, 4'd2, 8'h44, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8'h00, 4'd1, 8'h55, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 8'h00, 4'd0, 8'h00, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 8'hA5, 4'd1, 8'hA5, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 8'h00, 4'd0, 8'h00, 1'b0, 1'b1};

        #2;
        check("reset.count",  32'(count_o),        32'd0);
        check("reset.empty",  32'(empty_o),        32'd1);
        check("reset.aempty", 32'(almost_empty_o), 32'd1);
        check("reset.full",   32'(full_o),         32'd0);
        check("reset.afull",  32'(almost_full_o),  32'd0);
        check("reset.rdata",  32'(rd_data_o),      32'd0);
        check("reset.ovf",    32'(overflow_o),     32'd0);
        check("reset.unf",    32'(underflow_o),    32'd0);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Fill, drop on full, pop-only on full, drain, push-only on empty.
        for (int i = 0; i < 13; i++) begin
            step($sformatf("vec%0d", i), 1'b0, vecs[i].wr, vecs[i].rd, vecs[i].data);
            check($sformatf("vec%0d.tcount", i), 32'(count_o),   32'(vecs[i].exp_count));
            check($sformatf("vec%0d.trdata", i), 32'(rd_data_o), 32'(vecs[i].exp_rdata));
            check($sformatf("vec%0d.tfull", i),  32'(full_o),    32'(vecs[i].exp_full));
            check($sformatf("vec%0d.tempty", i), 32'(empty_o),   32'(vecs[i].exp_empty));
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        check("sticky.ovf", 32'(overflow_o),  32'd1);
        check("sticky.unf", 32'(underflow_o), 32'd1);
`else
        check("tied.ovf", 32'(overflow_o),  32'd0);
        check("tied.unf", 32'(underflow_o), 32'd0);
`endif

        // Wrap: occupancy held at 3 across 20 simultaneous push/pop pairs.
        do_reset();
        for (int i = 0; i < 3; i++) step("wrap_fill", 1'b0, 1'b1, 1'b0, 8'(i));
        for (int i = 0; i < 20; i++) begin
            check("wrap.head", 32'(rd_data_o), 32'(i));
            step("wrap", 1'b0, 1'b1, 1'b1, 8'(i + 3));
            check("wrap.count3", 32'(count_o), 32'd3);
        end

        // Flush with a concurrent push, then an asynchronous reset between edges.
        step("pre_flush", 1'b0, 1'b0, 1'b1, 8'h00);
        step("pre_flush", 1'b0, 1'b1, 1'b0, 8'hC3);
        step("flush", 1'b1, 1'b1, 1'b0, 8'hEE);
        check("flush.count", 32'(count_o), 32'd0);
        check("flush.empty", 32'(empty_o), 32'd1);
        step("post_flush", 1'b0, 1'b1, 1'b0, 8'h5A);
        step("post_flush", 1'b0, 1'b1, 1'b0, 8'h5B);
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst.count", 32'(count_o),   32'd0);
        check("async_rst.empty", 32'(empty_o),   32'd1);
        check("async_rst.rdata", 32'(rd_data_o), 32'd0);
        model_clear();
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check_model("after_rst");

        // Random traffic in phases biased toward filling and draining.
        for (int i = 0; i < 600; i++) begin
            logic f, w, r;
            ph = (i / 75) % 2;
            f  = ($urandom_range(0, 49) == 0);
            w  = ($urandom_range(0, 99) < (ph == 0 ? 75 : 35));
            r  = ($urandom_range(0, 99) < (ph == 0 ? 35 : 75));
            step("rand", f, w, r, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
